alu_unit: RTL and testbench
===========================

// Module: alu_unit
// PURPOSE
//  Single-cycle integer ALU execution unit of the CVA5 pipeline (RV32I add/sub, slt/sltu, xor/or/and, sll/srl/sra).
//  Accepts pre-decoded operands (alu_inputs_t) via func_unit_ex_interface; one-entry result register drives
//  unit_writeback_interface, held until writeback accepts it.
// PARAMETERS
//  none; XLEN=32 taken from cva5_config package.
// PORTS
//  clk         in   1                 clock, all state on rising edge
//  rst         in   1                 reset; asynchronous, active-low (0 = reset)
//  alu_ex      ifc  func_unit_ex_interface  unit side: new_request_dec (in), ready (out)
//  alu_wb      ifc  unit_writeback_interface unit side: done_next_cycle (out), rd[31:0] (out), accepted (in)
//  alu_inputs  in   alu_inputs_t      in1[32:0], in2[32:0], subtract, arith, lshift, shifter_in[31:0], logic_op[1:0], op[1:0]
// BEHAVIOUR
//  - Reset (rst=0, async): valid<=0, rd<=0; so done_next_cycle=0, ready=1. Reset mid-operation discards held result.
//  - Issue: request taken on posedge when new_request_dec & ready. ready = ~valid | accepted (comb).
//  - Latency: result registered at issue edge; done_next_cycle=valid high the cycle after issue.
//  - rd stable and valid whenever done_next_cycle=1; held indefinitely until accepted (no overwrite).
//  - accepted (1-cycle pulse, only while valid): clears valid; simultaneous accepted & new request ->
//    new result loaded, valid stays 1 (back-to-back, no bubble). accepted while ~valid is ignored.
//  - Datapath (33-bit adder, uses 33rd operand bit from decode: sign-pad for signed slt, 0 for unsigned):
//    sum[32:0] = in1 + (in2 ^ {33{subtract}}) + subtract.
//  - logic_op: ADD->sum[31:0]; XOR/OR/AND -> in1[31:0] op in2[31:0] (subtract ignored).
//  - op ALU_ADD_SUB(2'b00): logic result. op ALU_SLT(2'b01): {31'b0, sum[32]} (decode sets subtract=1;
//    with subtract=0 result is bit 32 of the add). op ALU_SHIFT(2'b10): shift result. 2'b11: treat as ADD_SUB.
//  - Shift: shifter_in = lshift ? bitreverse(in1) : in1 (supplied by decode). Compute
//    r = signed'({arith & shifter_in[31], shifter_in}) >>> in2[4:0]; out = lshift ? bitreverse(r[31:0]) : r[31:0].
//    Only in2[4:0] used; amount 0 passes operand unchanged; arith only meaningful for right shift.
//  - All arithmetic wraps mod 2^32 on rd; no exceptions/flags.
// STRUCTURE
//  - cva5_types: alu_inputs_t; alu_op_t {ALU_ADD_SUB=0, ALU_SLT=1, ALU_SHIFT=2};
//    alu_logic_op_t {ALU_LOGIC_XOR, ALU_LOGIC_OR, ALU_LOGIC_AND, ALU_LOGIC_ADD}; fn3 constants
//    (ADD_SUB, SLL, SLT, SLTU, XOR, SRA, OR, AND) in cva5_config.
//  - One sub-module: barrel_shifter (33-bit arithmetic right shift, 5-bit amount); rest inline in alu_unit.
// TESTING
//  - Add/sub: in1=3,in2=7 sub=0 -> rd=0x0000000A; sub=1 -> rd=0xFFFFFFFC; 0-0 sub -> 0.
//  - Logic: in1=0xFF00FF00,in2=0x0F0F0F0F: AND->0x0F000F00, OR->0xFF0FFF0F, XOR->0xF00FF00F.
//  - SLT: op=01,sub=1: 3 vs 7 -> 1; 1 vs 1 -> 0; sub=0 3+7 -> 0; in1=33'h1_FFFFFFFF,in2=1 -> 1 (signed -1<1).
//  - Shifts: lshift 0x21212121<<7 -> 0x90909080; 0xFFFFFFFF<<31 -> 0x80000000; srl 0x81818181>>7 ->
//    0x01030303; sra 0x81818181>>7 -> 0xFF030303; sra 0x80000000>>31 -> 0xFFFFFFFF; amount 0 -> in1.
//  - Handshake: hold accepted low 15 cycles -> rd/done_next_cycle stable, ready=0; accepted with same-cycle
//    request -> next result next cycle, no gap; 1000 random ops with random 0..15 accept delay match model.
//  - Reset: assert rst=0 while result pending -> done_next_cycle=0, rd=0, ready=1 immediately.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared types for the integer ALU execution unit: operand bundle, op selects and helpers.
package alu_unit_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ALU_ADD_SUB = 2'b00,
      ALU_SLT     = 2'b01,
      ALU_SHIFT   = 2'b10
   } alu_op_t;

   typedef enum logic [1:0] {
      ALU_LOGIC_XOR = 2'b00,
      ALU_LOGIC_OR  = 2'b01,
      ALU_LOGIC_AND = 2'b10,
      ALU_LOGIC_ADD = 2'b11
   } alu_logic_op_t;

   typedef enum logic [2:0] {
      FN3_ADD_SUB = 3'b000,
      FN3_SLL     = 3'b001,
      FN3_SLT     = 3'b010,
      FN3_SLTU    = 3'b011,
      FN3_XOR     = 3'b100,
      FN3_SRL_SRA = 3'b101,
      FN3_OR      = 3'b110,
      FN3_AND     = 3'b111
   } fn3_t;

   // op/logic_op kept as raw 2-bit fields so decode may present the unused 2'b11 op encoding
   typedef struct packed {
      logic [XLEN:0]   in1;
      logic [XLEN:0]   in2;
      logic            subtract;
      logic            arith;
      logic            lshift;
      logic [XLEN-1:0] shifter_in;
      logic [1:0]      logic_op;
      logic [1:0]      op;
   } alu_inputs_t;

   function automatic logic [XLEN-1:0] bitreverse(input logic [XLEN-1:0] v);
      logic [XLEN-1:0] r;
      for (int unsigned i = 0; i < XLEN; i++) begin
         r[i] = v[XLEN-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_unit_barrel_shifter.sv
// 33-bit arithmetic right barrel shifter, five log2 stages.
module alu_unit_barrel_shifter (
   input  logic [32:0] data_i,
   input  logic [4:0]  shamt_i,
   output logic [32:0] data_o
);

   logic [32:0] stage [6];

   always_comb begin
      stage[0] = data_i;
      for (int unsigned i = 0; i < 5; i++) begin
         stage[i+1] = shamt_i[i] ? 33'($signed(stage[i]) >>> (1 << i)) : stage[i];
      end
   end

   assign data_o = stage[5];

endmodule

// File: rtl/alu_unit.sv
// Single-cycle RV32I integer ALU with a one-entry result register toward writeback.
module alu_unit
   import alu_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              new_request_dec_i,
   output logic              ready_o,
   output logic              done_next_cycle_o,
   output logic [XLEN-1:0]   rd_o,
   input  logic              accepted_i,
   input  alu_inputs_t       alu_inputs_i
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shift_in_ext;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] logic_result;
   logic [XLEN-1:0] shift_result;
   logic [XLEN-1:0] result;
   logic            issue;

   logic            valid_q, valid_d;
   logic [XLEN-1:0] rd_q, rd_d;

   // 33rd operand bit comes from decode: sign-pad for slt, zero-pad for sltu
   assign sum = alu_inputs_i.in1
              + (alu_inputs_i.in2 ^ {(XLEN+1){alu_inputs_i.subtract}})
              + {{XLEN{1'b0}}, alu_inputs_i.subtract};

   always_comb begin
      logic_result = sum[XLEN-1:0];
      case (alu_inputs_i.logic_op)
         ALU_LOGIC_XOR: logic_result = alu_inputs_i.in1[XLEN-1:0] ^ alu_inputs_i.in2[XLEN-1:0];
         ALU_LOGIC_OR:  logic_result = alu_inputs_i.in1[XLEN-1:0] | alu_inputs_i.in2[XLEN-1:0];
         ALU_LOGIC_AND: logic_result = alu_inputs_i.in1[XLEN-1:0] & alu_inputs_i.in2[XLEN-1:0];
         default:       logic_result = sum[XLEN-1:0];
      endcase
   end

   // Left shifts reuse the right shifter on a bit-reversed operand
   assign shift_in_ext = {alu_inputs_i.arith & alu_inputs_i.shifter_in[XLEN-1], alu_inputs_i.shifter_in};

   alu_unit_barrel_shifter u_shifter (
      .data_i  (shift_in_ext),
      .shamt_i (alu_inputs_i.in2[4:0]),
      .data_o  (shifted)
   );

   assign shift_result = alu_inputs_i.lshift ? bitreverse(shifted[XLEN-1:0]) : shifted[XLEN-1:0];

   always_comb begin
      result = logic_result;
      case (alu_inputs_i.op)
         ALU_SLT:   result = {{(XLEN-1){1'b0}}, sum[XLEN]};
         ALU_SHIFT: result = shift_result;
         default:   result = logic_result;
      endcase
   end

   assign ready_o = ~valid_q | accepted_i;
   assign issue   = new_request_dec_i & ready_o;

   always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      if (issue) begin
         valid_d = 1'b1;
         rd_d    = result;
      end else if (accepted_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         rd_q    <= '0;
      end else begin
         valid_q <= valid_d;
         rd_q    <= rd_d;
      end
   end

   assign done_next_cycle_o = valid_q;
   assign rd_o              = rd_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed and randomized self-checking bench for alu_unit.
module tb_alu_unit;
   import alu_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic        acc = 1'b0;
   logic        ready;
   logic        done;
   logic [31:0] rd;
   alu_inputs_t ain = '0;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   alu_unit dut (
      .clk               (clk),
      .rst               (rst),
      .new_request_dec_i (req),
      .ready_o           (ready),
      .done_next_cycle_o (done),
      .rd_o              (rd),
      .accepted_i        (acc),
      .alu_inputs_i      (ain)
   );

   function automatic logic [31:0] rev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   function automatic alu_inputs_t mk(input logic [32:0] a, input logic [32:0] b, input logic sub,
                                      input logic arith, input logic lsh, input logic [1:0] lop,
                                      input logic [1:0] op);
      alu_inputs_t x;
      x.in1        = a;
      x.in2        = b;
      x.subtract   = sub;
      x.arith      = arith;
      x.lshift     = lsh;
      x.shifter_in = lsh ? rev32(a[31:0]) : a[31:0];
      x.logic_op   = lop;
      x.op         = op;
      return x;
   endfunction

   task automatic run_op(input alu_inputs_t x, output logic [31:0] r, output logic d);
      @(negedge clk);
      ain = x;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      r   = rd;
      d   = done;
      acc = 1'b1;
      @(negedge clk);
      acc = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      vectors++;
      if (ready !== 1'b1 || done !== 1'b0 || rd !== 32'h0) begin
         miscompares++;
         $display("FAIL reset: ready=%b done=%b rd=%h, expected ready=1 done=0 rd=00000000", ready, done, rd);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_add_sub;
      alu_inputs_t v[5];
      logic [31:0] e[5];
      logic [31:0] r;
      logic        d;
      v[0] = mk(33'd3, 33'd7, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);                   e[0] = 32'h0000000A;
      v[1] = mk(33'd3, 33'd7, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00);                   e[1] = 32'hFFFFFFFC;
      v[2] = mk(33'd0, 33'd0, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00);                   e[2] = 32'h00000000;
      v[3] = mk(33'h0_FFFFFFFF, 33'd1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);         e[3] = 32'h00000000;
      v[4] = mk(33'd3, 33'd7, 1'b0, 1'b0, 1'b0, 2'b11, 2'b11);                   e[4] = 32'h0000000A;
      for (int i = 0; i < 5; i++) begin
         run_op(v[i], r, d);
         vectors++;
         if (r !== e[i] || d !== 1'b1) begin
            miscompares++;
            $display("FAIL add_sub[%0d]: rd=%h done=%b, expected rd=%h done=1", i, r, d, e[i]);
         end
      end
   endtask

   task automatic test_logic;
      alu_inputs_t v[3];
      logic [31:0] e[3];
      logic [31:0] r;
      logic        d;
      v[0] = mk(33'h0FF00FF00, 33'h00F0F0F0F, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00); e[0] = 32'h0F000F00;
      v[1] = mk(33'h0FF00FF00, 33'h00F0F0F0F, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00); e[1] = 32'hFF0FFF0F;
      v[2] = mk(33'h0FF00FF00, 33'h00F0F0F0F, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00); e[2] = 32'hF00FF00F;
      for (int i = 0; i < 3; i++) begin
         run_op(v[i], r, d);
         vectors++;
         if (r !== e[i] || d !== 1'b1) begin
            miscompares++;
            $display("FAIL logic[%0d]: rd=%h done=%b, expected rd=%h done=1", i, r, d, e[i]);
         end
      end
   endtask

   task automatic test_slt;
      alu_inputs_t v[6];
      logic [31:0] e[6];
      logic [31:0] r;
      logic        d;
      v[0] = mk(33'd3, 33'd7, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01);                   e[0] = 32'd1;
      v[1] = mk(33'd1, 33'd1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01);                   e[1] = 32'd0;
      v[2] = mk(33'd3, 33'd7, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01);                   e[2] = 32'd0;
      v[3] = mk(33'h1_FFFFFFFF, 33'd1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01);         e[3] = 32'd1;
      v[4] = mk(33'h0_FFFFFFFF, 33'd1, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01);         e[4] = 32'd0;
      v[5] = mk(33'd1, 33'h0_FFFFFFFF, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01);         e[5] = 32'd1;
      for (int i = 0; i < 6; i++) begin
         run_op(v[i], r, d);
         vectors++;
         if (r !== e[i] || d !== 1'b1) begin
            miscompares++;
            $display("FAIL slt[%0d]: rd=%h done=%b, expected rd=%h done=1", i, r, d, e[i]);
         end
      end
   endtask

   task automatic test_shift;
      alu_inputs_t v[8];
      logic [31:0] e[8];
      logic [31:0] r;
      logic        d;
      v[0] = mk(33'h021212121, 33'd7,  1'b0, 1'b0, 1'b1, 2'b11, 2'b10);         e[0] = 32'h90909080;
      v[1] = mk(33'h0FFFFFFFF, 33'd31, 1'b0, 1'b0, 1'b1, 2'b11, 2'b10);         e[1] = 32'h80000000;
      v[2] = mk(33'h081818181, 33'd7,  1'b0, 1'b0, 1'b0, 2'b11, 2'b10);         e[2] = 32'h01030303;
      v[3] = mk(33'h081818181, 33'd7,  1'b0, 1'b1, 1'b0, 2'b11, 2'b10);         e[3] = 32'hFF030303;
      v[4] = mk(33'h080000000, 33'd31, 1'b0, 1'b1, 1'b0, 2'b11, 2'b10);         e[4] = 32'hFFFFFFFF;
      v[5] = mk(33'h012345678, 33'd0,  1'b0, 1'b1, 1'b0, 2'b11, 2'b10);         e[5] = 32'h12345678;
      v[6] = mk(33'h012345678, 33'd0,  1'b0, 1'b0, 1'b1, 2'b11, 2'b10);         e[6] = 32'h12345678;
      v[7] = mk(33'h080000000, 33'h25, 1'b0, 1'b0, 1'b0, 2'b11, 2'b10);         e[7] = 32'h04000000;
      for (int i = 0; i < 8; i++) begin
         run_op(v[i], r, d);
         vectors++;
         if (r !== e[i] || d !== 1'b1) begin
            miscompares++;
            $display("FAIL shift[%0d]: rd=%h done=%b, expected rd=%h done=1", i, r, d, e[i]);
         end
      end
   endtask

   task automatic test_hold;
      @(negedge clk);
      ain = mk(33'd3, 33'd7, 1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      ain = mk(33'd100, 33'd1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
      for (int i = 0; i < 15; i++) begin
         vectors++;
         if (done !== 1'b1 || rd !== 32'hFFFFFFFC || ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold[%0d]: done=%b rd=%h ready=%b, expected done=1 rd=fffffffc ready=0",
                     i, done, rd, ready);
         end
         @(negedge clk);
      end
      acc = 1'b1;
      #1;
      vectors++;
      if (ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_accept_ready: ready=%b, expected 1", ready);
      end
      @(negedge clk);
      acc = 1'b0;
      vectors++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_cleared: done=%b ready=%b, expected done=0 ready=1", done, ready);
      end
      acc = 1'b1;
      @(negedge clk);
      acc = 1'b0;
      vectors++;
      if (done !== 1'b0 || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL idle_accept: done=%b ready=%b, expected done=0 ready=1", done, ready);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] e[3];
      alu_inputs_t v[3];
      v[0] = mk(33'd3, 33'd7, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);                   e[0] = 32'h0000000A;
      v[1] = mk(33'h0FF00FF00, 33'h00F0F0F0F, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00); e[1] = 32'hF00FF00F;
      v[2] = mk(33'h081818181, 33'd7, 1'b0, 1'b1, 1'b0, 2'b11, 2'b10);          e[2] = 32'hFF030303;
      @(negedge clk);
      ain = v[0];
      req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (done !== 1'b1 || rd !== e[i]) begin
            miscompares++;
            $display("FAIL back_to_back[%0d]: done=%b rd=%h, expected done=1 rd=%h", i, done, rd, e[i]);
         end
         acc = 1'b1;
         if (i < 2) ain = v[i+1];
         else       req = 1'b0;
      end
      @(negedge clk);
      acc = 1'b0;
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("FAIL back_to_back_drain: done=%b, expected 0", done);
      end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      ain = mk(33'd3, 33'd7, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      vectors++;
      if (done !== 1'b1 || rd !== 32'h0000000A) begin
         miscompares++;
         $display("FAIL reset_mid_pending: done=%b rd=%h, expected done=1 rd=0000000a", done, rd);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (done !== 1'b0 || rd !== 32'h0 || ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid: done=%b rd=%h ready=%b, expected done=0 rd=00000000 ready=1",
                  done, rd, ready);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_random;
      logic [31:0] exp_q   = '0;
      bit          pending = 1'b0;
      logic [31:0] a, b, e;
      logic [1:0]  lop;
      logic        sub, ar;
      int unsigned kind, dly;
      alu_inputs_t x;
      for (int i = 0; i < 1000; i++) begin
         a    = $urandom;
         b    = $urandom;
         sub  = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 5);
         case (kind)
            0: begin
               x = mk({1'b0, a}, {1'b0, b}, sub, 1'b0, 1'b0, 2'b11, ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
               e = sub ? a - b : a + b;
            end
            1: begin
               lop = 2'($urandom_range(0, 2));
               x   = mk({1'b0, a}, {1'b0, b}, sub, 1'b0, 1'b0, lop, 2'b00);
               e   = (lop == 2'd0) ? (a ^ b) : (lop == 2'd1) ? (a | b) : (a & b);
            end
            2: begin
               x = mk({a[31], a}, {b[31], b}, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01);
               e = {31'b0, ($signed(a) < $signed(b))};
            end
            3: begin
               x = mk({1'b0, a}, {1'b0, b}, 1'b1, 1'b0, 1'b0, 2'b11, 2'b01);
               e = {31'b0, (a < b)};
            end
            4: begin
               x = mk({1'b0, a}, {1'b0, b}, 1'b0, 1'b0, 1'b1, 2'b11, 2'b10);
               e = a << b[4:0];
            end
            default: begin
               ar = 1'($urandom_range(0, 1));
               x  = mk({1'b0, a}, {1'b0, b}, 1'b0, ar, 1'b0, 2'b11, 2'b10);
               e  = ar ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            end
         endcase
         @(negedge clk);
         ain = x;
         req = 1'b1;
         acc = pending;
         @(negedge clk);
         req     = 1'b0;
         acc     = 1'b0;
         exp_q   = e;
         pending = 1'b1;
         vectors++;
         if (done !== 1'b1 || rd !== exp_q) begin
            miscompares++;
            $display("FAIL random[%0d] kind=%0d: done=%b rd=%h, expected done=1 rd=%h", i, kind, done, rd, exp_q);
         end
         dly = $urandom_range(0, 15);
         repeat (dly) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b1 || rd !== exp_q || ready !== 1'b0) begin
               miscompares++;
               $display("FAIL random_hold[%0d]: done=%b rd=%h ready=%b, expected done=1 rd=%h ready=0",
                        i, done, rd, ready, exp_q);
            end
         end
         if ($urandom_range(0, 1) == 1) begin
            acc = 1'b1;
            @(negedge clk);
            acc     = 1'b0;
            pending = 1'b0;
            vectors++;
            if (done !== 1'b0 || ready !== 1'b1) begin
               miscompares++;
               $display("FAIL random_accept[%0d]: done=%b ready=%b, expected done=0 ready=1", i, done, ready);
            end
         end
      end
      if (pending) begin
         acc = 1'b1;
         @(negedge clk);
         acc = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_logic();
      test_slt();
      test_shift();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
